// File: rtl/mem_access_unit.sv
// MEM-stage controller in front of a word-wide, 1-cycle-read data memory.
// Handles word accesses directly, sub-word stores by read-modify-write, and load extension.
module mem_access_unit #(
   parameter bit          CHECK_ALIGN = 1'b1,
   parameter int unsigned OP_W        = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   input  logic [OP_W-1:0] req_op,
   input  logic [31:0]     req_addr,
   input  logic [31:0]     req_wdata,
   output logic            stall,
   output logic [31:0]     dm_address,
   output logic [31:0]     dm_data_in,
   output logic            dm_r,
   output logic            dm_w,
   input  logic [31:0]     dm_data_out,
   output logic            wb_valid,
   output logic [31:0]     wb_data,
   output logic            align_err
);

   localparam logic DM_R_ON  = 1'b1;
   localparam logic DM_R_OFF = 1'b0;
   localparam logic DM_W_ON  = 1'b1;
   localparam logic DM_W_OFF = 1'b0;

   localparam logic [OP_W-1:0] OP_LW  = OP_W'(1);
   localparam logic [OP_W-1:0] OP_LH  = OP_W'(2);
   localparam logic [OP_W-1:0] OP_LHU = OP_W'(3);
   localparam logic [OP_W-1:0] OP_LB  = OP_W'(4);
   localparam logic [OP_W-1:0] OP_LBU = OP_W'(5);
   localparam logic [OP_W-1:0] OP_SW  = OP_W'(6);
   localparam logic [OP_W-1:0] OP_SH  = OP_W'(7);
   localparam logic [OP_W-1:0] OP_SB  = OP_W'(8);

   typedef enum logic [1:0] {IDLE, LOAD_WAIT, RMW_WRITE} state_t;

   state_t      state, state_nxt;
   logic        is_load, is_sw, is_sub, addr_bad, misaligned;
   logic        wb_set, err_set;
   logic [4:0]  lane_sh;
   logic [31:0] lane_mask, lane_data, merged, ld_result;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   assign dm_address = {req_addr[31:2], 2'b00};
   assign misaligned = CHECK_ALIGN && addr_bad;

   // Opcode decode and alignment rule per access size
   always_comb begin
      is_load  = 1'b0;
      is_sw    = 1'b0;
      is_sub   = 1'b0;
      addr_bad = 1'b0;
      case (req_op)
         OP_LW:          begin is_load = 1'b1; addr_bad = |req_addr[1:0]; end
         OP_LH, OP_LHU:  begin is_load = 1'b1; addr_bad = req_addr[0];    end
         OP_LB, OP_LBU:  is_load = 1'b1;
         OP_SW:          begin is_sw   = 1'b1; addr_bad = |req_addr[1:0]; end
         OP_SH:          begin is_sub  = 1'b1; addr_bad = req_addr[0];    end
         OP_SB:          is_sub = 1'b1;
         default:        ;
      endcase
   end

   // Load lane extraction with sign/zero extension
   always_comb begin
      ld_byte = 8'(dm_data_out >> {req_addr[1:0], 3'b000});
      ld_half = 16'(dm_data_out >> {req_addr[1], 4'b0000});
      case (req_op)
         OP_LH:   ld_result = {{16{ld_half[15]}}, ld_half};
         OP_LHU:  ld_result = {16'h0000, ld_half};
         OP_LB:   ld_result = {{24{ld_byte[7]}}, ld_byte};
         OP_LBU:  ld_result = {24'h000000, ld_byte};
         default: ld_result = dm_data_out;
      endcase
   end

   // Store-lane merge into the word read back during the RMW
   always_comb begin
      if (req_op == OP_SB) begin
         lane_sh   = {req_addr[1:0], 3'b000};
         lane_mask = 32'h0000_00FF << lane_sh;
         lane_data = 32'(req_wdata[7:0]) << lane_sh;
      end else begin
         lane_sh   = {req_addr[1], 4'b0000};
         lane_mask = 32'h0000_FFFF << lane_sh;
         lane_data = 32'(req_wdata[15:0]) << lane_sh;
      end
      merged = (dm_data_out & ~lane_mask) | (lane_data & lane_mask);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         wb_valid  <= 1'b0;
         wb_data   <= 32'h0;
         align_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         wb_valid  <= wb_set;
         align_err <= err_set;
         if (wb_set) wb_data <= ld_result;
      end
   end

   // Next state and DM strobes; everything held inactive during reset
   always_comb begin
      state_nxt  = state;
      stall      = 1'b0;
      dm_r       = DM_R_OFF;
      dm_w       = DM_W_OFF;
      dm_data_in = req_wdata;
      wb_set     = 1'b0;
      err_set    = 1'b0;
      if (!rst) begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  if (misaligned) begin
                     err_set = 1'b1;
                  end else if (is_sw) begin
                     dm_w = DM_W_ON;
                  end else if (is_load) begin
                     dm_r      = DM_R_ON;
                     stall     = 1'b1;
                     state_nxt = LOAD_WAIT;
                  end else if (is_sub) begin
                     dm_r      = DM_R_ON;
                     stall     = 1'b1;
                     state_nxt = RMW_WRITE;
                  end
               end
            end
            LOAD_WAIT: begin
               wb_set    = 1'b1;
               state_nxt = IDLE;
            end
            RMW_WRITE: begin
               dm_w       = DM_W_ON;
               dm_data_in = merged;
               state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, reset corner sequences,
// and random traffic against a byte-level memory model.
module tb_mem_access_unit;

   localparam int K_NOP = 0;
   localparam int K_LOAD = 1;
   localparam int K_SW = 2;
   localparam int K_RMW = 3;
   localparam int K_MIS = 4;

   logic        clk, rst, req_valid;
   logic [3:0]  req_op;
   logic [31:0] req_addr, req_wdata;
   logic        stall, dm_r, dm_w, wb_valid, align_err;
   logic [31:0] dm_address, dm_data_in, dm_data_out, wb_data;

   bit [31:0] dm_mem [64];
   bit [31:0] ref_mem [64];
   int n_cmp = 0;
   int n_fail = 0;

   mem_access_unit #(.CHECK_ALIGN(1'b1), .OP_W(4)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall),
      .dm_address(dm_address), .dm_data_in(dm_data_in), .dm_r(dm_r),
      .dm_w(dm_w), .dm_data_out(dm_data_out), .wb_valid(wb_valid),
      .wb_data(wb_data), .align_err(align_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word-wide data memory with registered read
   always @(posedge clk) begin
      if (dm_w) dm_mem[dm_address[7:2]] <= dm_data_in;
      if (dm_r) dm_data_out <= dm_mem[dm_address[7:2]];
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: byte-granular access semantics over ref_mem
   task automatic model(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        output int kind, output logic [31:0] val);
      int size;
      bit ld, sgn;
      int off;
      logic [31:0] w;
      size = 0; ld = 0; sgn = 0; val = 32'h0;
      case (op)
         4'd1: begin size = 4; ld = 1; end
         4'd2: begin size = 2; ld = 1; sgn = 1; end
         4'd3: begin size = 2; ld = 1; end
         4'd4: begin size = 1; ld = 1; sgn = 1; end
         4'd5: begin size = 1; ld = 1; end
         4'd6: size = 4;
         4'd7: size = 2;
         4'd8: size = 1;
         default: size = 0;
      endcase
      off = int'(addr[1:0]);
      w = ref_mem[addr[7:2]];
      if (size == 0) kind = K_NOP;
      else if (off % size != 0) kind = K_MIS;
      else if (ld) begin
         kind = K_LOAD;
         for (int i = 0; i < size; i++) val[8*i +: 8] = w[8*(off+i) +: 8];
         if (sgn && val[8*size-1])
            for (int i = size; i < 4; i++) val[8*i +: 8] = 8'hFF;
      end else begin
         kind = (size == 4) ? K_SW : K_RMW;
         for (int i = 0; i < size; i++) w[8*(off+i) +: 8] = wdata[8*i +: 8];
         ref_mem[addr[7:2]] = w;
         val = w;
      end
   endtask

   // One request: issue cycle, follow-up cycle, writeback cycle
   task automatic txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                      input int kind, input logic [31:0] exp, input string tag);
      bit rd, wr;
      rd = (kind == K_LOAD) || (kind == K_RMW);
      wr = (kind == K_SW);
      @(negedge clk);
      req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
      #1;
      chk({tag, ".stall"}, 32'(stall), 32'(rd));
      chk({tag, ".dm_r"}, 32'(dm_r), 32'(rd));
      chk({tag, ".dm_w"}, 32'(dm_w), 32'(wr));
      if (rd || wr) chk({tag, ".dm_address"}, dm_address, addr & 32'hFFFF_FFFC);
      if (wr) chk({tag, ".sw_data"}, dm_data_in, exp);
      @(negedge clk);
      if (!rd) req_valid = 1'b0;
      #1;
      if (kind == K_LOAD) begin
         chk({tag, ".wait_stall"}, 32'(stall), 32'd0);
         chk({tag, ".wait_en"}, 32'({dm_r, dm_w}), 32'd0);
      end else if (kind == K_RMW) begin
         chk({tag, ".rmw_w"}, 32'({dm_r, dm_w, stall}), 32'b010);
         chk({tag, ".rmw_data"}, dm_data_in, exp);
      end else begin
         chk({tag, ".align_err"}, 32'(align_err), 32'(kind == K_MIS));
         chk({tag, ".no_wb"}, 32'(wb_valid), 32'd0);
      end
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      chk({tag, ".wb_valid"}, 32'(wb_valid), 32'(kind == K_LOAD));
      if (kind == K_LOAD) chk({tag, ".wb_data"}, wb_data, exp);
      chk({tag, ".err_end"}, 32'(align_err), 32'd0);
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          kind;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [17];

   initial begin
      int kind;
      logic [31:0] val;
      logic [3:0]  rop;
      logic [31:0] raddr, rdata;

      tbl[0]  = '{4'd6, 32'h10, 32'hDEADBEEF, K_SW,   32'hDEADBEEF};
      tbl[1]  = '{4'd1, 32'h10, 32'h0,        K_LOAD, 32'hDEADBEEF};
      tbl[2]  = '{4'd6, 32'h10, 32'h8081F2F3, K_SW,   32'h8081F2F3};
      tbl[3]  = '{4'd4, 32'h11, 32'h0,        K_LOAD, 32'hFFFFFFF2};
      tbl[4]  = '{4'd5, 32'h13, 32'h0,        K_LOAD, 32'h00000080};
      tbl[5]  = '{4'd2, 32'h12, 32'h0,        K_LOAD, 32'hFFFF8081};
      tbl[6]  = '{4'd3, 32'h10, 32'h0,        K_LOAD, 32'h0000F2F3};
      tbl[7]  = '{4'hF, 32'h10, 32'h5,        K_NOP,  32'h0};
      tbl[8]  = '{4'd6, 32'h20, 32'h11223344, K_SW,   32'h11223344};
      tbl[9]  = '{4'd8, 32'h21, 32'h000000AA, K_RMW,  32'h1122AA44};
      tbl[10] = '{4'd1, 32'h20, 32'h0,        K_LOAD, 32'h1122AA44};
      tbl[11] = '{4'd6, 32'h20, 32'h11223344, K_SW,   32'h11223344};
      tbl[12] = '{4'd7, 32'h22, 32'h0000BEEF, K_RMW,  32'hBEEF3344};
      tbl[13] = '{4'd7, 32'h21, 32'h00001234, K_MIS,  32'h0};
      tbl[14] = '{4'd1, 32'h20, 32'h0,        K_LOAD, 32'hBEEF3344};
      tbl[15] = '{4'd0, 32'h20, 32'h0,        K_NOP,  32'h0};
      tbl[16] = '{4'd1, 32'h10, 32'h0,        K_LOAD, 32'h8081F2F3};

      // Reset with a pending load request: everything stays quiet
      rst = 1'b1; req_valid = 1'b1; req_op = 4'd1; req_addr = 32'h30; req_wdata = 32'h0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst.strobes", 32'({stall, dm_r, dm_w}), 32'd0);
      chk("rst.wb_valid", 32'(wb_valid), 32'd0);
      chk("rst.wb_data", wb_data, 32'h0);
      chk("rst.align_err", 32'(align_err), 32'd0);
      @(negedge clk);
      rst = 1'b0; req_valid = 1'b0;

      for (int i = 0; i < 17; i++) begin
         model(tbl[i].op, tbl[i].addr, tbl[i].wdata, kind, val);
         txn(tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].kind, tbl[i].exp, $sformatf("vec%0d", i));
      end
      chk("mis.mem_unchanged", dm_mem[8], 32'hBEEF3344);

      // req_valid low with a load opcode on the bus
      @(negedge clk);
      req_valid = 1'b0; req_op = 4'd1; req_addr = 32'h10;
      #1;
      chk("novalid.strobes", 32'({stall, dm_r, dm_w}), 32'd0);

      // Reset during LOAD_WAIT: no writeback
      @(negedge clk);
      req_valid = 1'b1; req_op = 4'd1; req_addr = 32'h30;
      #1;
      chk("rstld.stall", 32'(stall), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rstld.strobes", 32'({stall, dm_r, dm_w}), 32'd0);
      @(negedge clk);
      rst = 1'b0; req_valid = 1'b0;
      #1;
      chk("rstld.wb0", 32'(wb_valid), 32'd0);
      @(negedge clk);
      #1;
      chk("rstld.wb1", 32'(wb_valid), 32'd0);

      // Reset during RMW_WRITE: write abandoned, word unchanged
      @(negedge clk);
      req_valid = 1'b1; req_op = 4'd8; req_addr = 32'h21; req_wdata = 32'h55;
      #1;
      chk("rstrmw.dm_r", 32'(dm_r), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rstrmw.dm_w", 32'(dm_w), 32'd0);
      @(negedge clk);
      rst = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      chk("rstrmw.mem", dm_mem[8], 32'hBEEF3344);
      txn(4'd1, 32'h20, 32'h0, K_LOAD, 32'hBEEF3344, "rstrmw.lw");

      // Random traffic against the reference model
      for (int i = 0; i < 300; i++) begin
         rop   = 4'($urandom_range(0, 15));
         raddr = 32'($urandom_range(0, 255));
         rdata = $urandom;
         model(rop, raddr, rdata, kind, val);
         txn(rop, raddr, rdata, kind, val, "rnd");
      end
      for (int i = 0; i < 64; i++) chk("final.mem", dm_mem[i], ref_mem[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage controller sitting directly upstream of the word-wide data memory (DM); converts EX/MEM load/store requests into DM word accesses.
- DM interface: 1-cycle registered read, word-only write.
- Provides sub-word stores via read-modify-write, load byte/halfword extraction with sign/zero extension, and alignment checking.
- Stalls the pipeline while a DM access is in flight; delivers load results to MEM/WB with a valid pulse.

Parameters:
- CHECK_ALIGN, 1, 1 = misaligned accesses suppressed and flagged; 0 = low address bits ignored, access performed on the containing word/halfword.
- OP_W, 4, width of req_op.

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  MEM-stage request present; upstream holds req_* stable while stall=1
- req_op  in  OP_W  0 NOP, 1 LW, 2 LH, 3 LHU, 4 LB, 5 LBU, 6 SW, 7 SH, 8 SB; other codes = NOP
- req_addr  in  32  byte address
- req_wdata  in  32  store data (SB uses [7:0], SH [15:0])
- stall  out  1  freeze EX/MEM and earlier stages this cycle
- dm_address  out  32  word address to DM, req_addr with [1:0] forced to 0
- dm_data_in  out  32  write word to DM
- dm_r  out  1  DM read enable, asserted = DM_R_ON encoding
- dm_w  out  1  DM write enable, asserted = DM_W_ON encoding
- dm_data_out  in  32  DM registered read data
- wb_valid  out  1  one-cycle pulse: wb_data holds a load result
- wb_data  out  32  extended load result
- align_err  out  1  one-cycle pulse: misaligned request dropped

Behaviour:
- Reset values: state=IDLE, wb_valid=0, wb_data=0, align_err=0.
- While rst=1, combinational outputs are also inactive: dm_r=0, dm_w=0, stall=0.
- Byte lanes are little-endian: byte k = bits [8k+7:8k]. Halfword at addr[1]=h occupies bits [16h+15:16h].
- Alignment: LW/SW need addr[1:0]=0; LH/LHU/SH need addr[0]=0; byte ops are always aligned.
- FSM states: IDLE, LOAD_WAIT, RMW_WRITE.
- IDLE, no valid request or NOP: dm_r=dm_w=0, stall=0, remain IDLE.
- IDLE, misaligned request with CHECK_ALIGN=1:
  - No DM access, stall=0.
  - align_err=1 next cycle for one cycle; wb_valid stays 0.
- IDLE, SW: dm_w=1 and dm_data_in=req_wdata in the same cycle, stall=0, remain IDLE. No wb_valid.
- IDLE, any load: dm_r=1, stall=1, go to LOAD_WAIT.
- LOAD_WAIT:
  - dm_data_out holds the addressed word.
  - Extract LW (whole word), LH/LB (sign-extend) or LHU/LBU (zero-extend).
  - Register the result into wb_data; wb_valid=1 in the following cycle.
  - stall=0, dm_r=dm_w=0, go to IDLE.
- Load latency: request cycle N (stall) -> consumed at end of N+1 -> wb_valid/wb_data in cycle N+2.
- IDLE, SH/SB: dm_r=1, stall=1, go to RMW_WRITE.
- RMW_WRITE:
  - dm_data_in = dm_data_out with the target lane(s) replaced by req_wdata[7:0] or [15:0]; dm_w=1.
  - stall=0, go to IDLE.
  - Total 2 cycles, 1 stall cycle.
- Back-to-back requests:
  - A request in the cycle after LOAD_WAIT/RMW_WRITE is handled in IDLE normally.
  - A load directly after SB/SH to the same word must see the merged value: the write commits at the RMW_WRITE edge and the next read is issued one cycle later.
- wb_valid and align_err are single-cycle pulses, never asserted together.
- req_valid must not drop while stall=1. If it does, the FSM still completes the started access using the current req_* values.
- rst asserted in LOAD_WAIT or RMW_WRITE:
  - Return to IDLE with no dm_w in that cycle; a partial RMW is abandoned and memory is unchanged.
  - No wb_valid pulse.
- dm_address is driven from req_addr in every state; its value is don't-care when dm_r=dm_w=0.

Test Plan:
1. SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> dm_w in 1 cycle with no stall; LW stalls 1 cycle; wb_valid 2 cycles after LW issue with wb_data=0xDEADBEEF.
2. Word 0x10=0x8081F2F3; LB 0x11 -> 0xFFFFFFF2; LBU 0x13 -> 0x00000080; LH 0x12 -> 0xFFFF8081; LHU 0x10 -> 0x0000F2F3.
3. Word 0x20=0x11223344; SB 0x21 data 0xAA, then LW 0x20 -> dm_w word 0x1122AA44 in the RMW_WRITE cycle; LW returns 0x1122AA44.
4. SH 0x22 data 0xBEEF on 0x11223344 -> 0xBEEF3344. Then SH 0x21 with CHECK_ALIGN=1 -> align_err pulse, no dm_r/dm_w, memory unchanged.
5. LW 0x30 with rst asserted during LOAD_WAIT -> no wb_valid; state IDLE. SB during RMW_WRITE with rst -> no dm_w, word unchanged.
6. Invalid op 0xF and req_valid=0 cycles interleaved with LW -> no DM enables and no stall for NOP cycles; LW timing as in scenario 1.
